// File: rtl/avr_fetch.sv
// avr_fetch: ATmega328p instruction fetch stage feeding the CU.
// Drives a sync 16-bit program memory, assembles 1/2-word instrs.
//
// Ports:
//   CLK          clock, rising edge
//   RST          async active-low reset
//   PM_ADDR      program memory word address (comb)
//   PM_EN        program memory read enable (comb)
//   PM_DATA      program memory word, one cycle after request
//   STALL        CU cannot accept the current instruction
//   REDIRECT     single-cycle fetch restart request
//   REDIRECT_PC  restart target word address
//   INSTR        first instruction word
//   INSTR_K      second word of two-word instrs, else 0
//   INSTR_PC     address of INSTR
//   INSTR_NPC    address after the instruction
//   INSTR_VALID  output holds an unconsumed instruction
module avr_fetch #(
  parameter int              PC_W         = 14,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] PM_ADDR,
  output logic            PM_EN,
  input  logic [15:0]     PM_DATA,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic [PC_W-1:0] REDIRECT_PC,
  output logic [15:0]     INSTR,
  output logic [15:0]     INSTR_K,
  output logic [PC_W-1:0] INSTR_PC,
  output logic [PC_W-1:0] INSTR_NPC,
  output logic            INSTR_VALID
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W1   = 2'd1,
    S_W2   = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_fpc;
  logic [PC_W-1:0] w_fpc_nxt;
  logic [PC_W-1:0] r_req_pc;
  logic [PC_W-1:0] w_req_pc_nxt;
  logic [15:0]     r_instr;
  logic [15:0]     w_instr_nxt;
  logic [15:0]     r_instr_k;
  logic [15:0]     w_instr_k_nxt;
  logic [PC_W-1:0] r_instr_pc;
  logic [PC_W-1:0] w_instr_pc_nxt;
  logic [PC_W-1:0] r_instr_npc;
  logic [PC_W-1:0] w_instr_npc_nxt;
  logic            r_valid;
  logic            w_valid_nxt;

  logic            w_hold;
  logic            w_two;
  logic [PC_W-1:0] w_fpc_inc;

  // LDS/STS and JMP/CALL carry a second word.
  function automatic logic is_two_word(
    input logic [15:0] w
  );
    return ((w & 16'hFC0F) == 16'h9000) ||
           ((w & 16'hFE0C) == 16'h940C);
  endfunction

  assign w_two     = is_two_word(PM_DATA);
  assign w_fpc_inc = r_fpc + PC_ONE;

  // A held instruction also freezes the memory so
  // PM_DATA still carries the pending word on release.
  assign w_hold = r_valid & STALL;

  assign PM_ADDR = REDIRECT ? REDIRECT_PC : r_fpc;
  assign PM_EN   = REDIRECT | ~w_hold;

  assign INSTR       = r_instr;
  assign INSTR_K     = r_instr_k;
  assign INSTR_PC    = r_instr_pc;
  assign INSTR_NPC   = r_instr_npc;
  assign INSTR_VALID = r_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_fpc_nxt       = r_fpc;
    w_req_pc_nxt    = r_req_pc;
    w_instr_nxt     = r_instr;
    w_instr_k_nxt   = r_instr_k;
    w_instr_pc_nxt  = r_instr_pc;
    w_instr_npc_nxt = r_instr_npc;
    w_valid_nxt     = r_valid;

    if (REDIRECT) begin
      // Memory is reading the target this edge.
      // Any half-built two-word instr is dropped.
      w_valid_nxt  = 1'b0;
      w_req_pc_nxt = REDIRECT_PC;
      w_fpc_nxt    = REDIRECT_PC + PC_ONE;
      w_state_nxt  = S_W1;
    end else if (w_hold) begin
      w_state_nxt = r_state;
    end else begin
      unique case (r_state)
        S_W1: begin
          w_instr_nxt    = PM_DATA;
          w_instr_pc_nxt = r_req_pc;
          if (w_two) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_W2;
          end else begin
            w_instr_k_nxt   = 16'h0000;
            w_instr_npc_nxt = r_req_pc + PC_ONE;
            w_valid_nxt     = 1'b1;
          end
          w_req_pc_nxt = r_fpc;
          w_fpc_nxt    = w_fpc_inc;
        end
        S_W2: begin
          w_instr_k_nxt   = PM_DATA;
          w_instr_npc_nxt = r_instr_pc + PC_TWO;
          w_valid_nxt     = 1'b1;
          w_state_nxt     = S_W1;
          w_req_pc_nxt    = r_fpc;
          w_fpc_nxt       = w_fpc_inc;
        end
        default: begin
          // First request after reset; data not yet back.
          w_valid_nxt  = 1'b0;
          w_req_pc_nxt = r_fpc;
          w_fpc_nxt    = w_fpc_inc;
          w_state_nxt  = S_W1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_fpc       <= RESET_VECTOR;
      r_req_pc    <= '0;
      r_instr     <= '0;
      r_instr_k   <= '0;
      r_instr_pc  <= '0;
      r_instr_npc <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fpc       <= w_fpc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_k   <= w_instr_k_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_instr_npc <= w_instr_npc_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_avr_fetch.sv
// tb_avr_fetch: bench for avr_fetch with a sync memory model
// and a scoreboard of expected consumed instructions.
module tb_avr_fetch;

  localparam int PC_W = 14;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [PC_W-1:0] PM_ADDR;
  logic            PM_EN;
  logic [15:0]     PM_DATA = 16'h0000;
  logic            STALL = 1'b0;
  logic            REDIRECT = 1'b0;
  logic [PC_W-1:0] REDIRECT_PC = '0;
  logic [15:0]     INSTR;
  logic [15:0]     INSTR_K;
  logic [PC_W-1:0] INSTR_PC;
  logic [PC_W-1:0] INSTR_NPC;
  logic            INSTR_VALID;

  logic [15:0] mem [0:16383];

  typedef struct packed {
    logic [15:0]     i;
    logic [15:0]     k;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  avr_fetch #(
    .PC_W(PC_W),
    .RESET_VECTOR(14'h0000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PM_ADDR    (PM_ADDR),
    .PM_EN      (PM_EN),
    .PM_DATA    (PM_DATA),
    .STALL      (STALL),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .INSTR      (INSTR),
    .INSTR_K    (INSTR_K),
    .INSTR_PC   (INSTR_PC),
    .INSTR_NPC  (INSTR_NPC),
    .INSTR_VALID(INSTR_VALID)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (PM_EN) PM_DATA <= mem[PM_ADDR];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [PC_W-1:0] pc);
    exp_t        e;
    logic [15:0] w;
    logic        two;
    w = mem[pc];
    two = ((w & 16'hFC0F) == 16'h9000) ||
          ((w & 16'hFE0C) == 16'h940C);
    e.i   = w;
    e.pc  = pc;
    e.k   = two ? mem[pc + 14'd1] : 16'h0000;
    e.npc = pc + (two ? 14'd2 : 14'd1);
    return e;
  endfunction

  task automatic push(input logic [PC_W-1:0] pc);
    sb.push_back(model(pc));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_instr"}, 32'(INSTR), 32'h0);
    check({tag, "_k"}, 32'(INSTR_K), 32'h0);
    check({tag, "_pc"}, 32'(INSTR_PC), 32'h0);
    check({tag, "_npc"}, 32'(INSTR_NPC), 32'h0);
    check({tag, "_valid"}, 32'(INSTR_VALID), 32'h0);
    check({tag, "_pmaddr"}, 32'(PM_ADDR), 32'h0);
    check({tag, "_pmen"}, 32'(PM_EN), 32'h1);
  endtask

  // Consumption happens at the next edge; inputs only
  // change just after posedge, so negedge sees them settled.
  always @(negedge CLK) begin
    if (RST && INSTR_VALID && !STALL) begin
      exp_t e;
      check("sb_nonempty", 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_instr", 32'(INSTR), 32'(e.i));
        check("sb_k", 32'(INSTR_K), 32'(e.k));
        check("sb_pc", 32'(INSTR_PC), 32'(e.pc));
        check("sb_npc", 32'(INSTR_NPC), 32'(e.npc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 16'h0000;
    mem[1]  = 16'hE0A5;
    mem[2]  = 16'h0F01;
    mem[3]  = 16'h9508;
    mem[4]  = 16'h940C;
    mem[5]  = 16'h0010;
    mem[6]  = 16'h0000;
    mem[16] = 16'hCFFF;

    #12;
    chk_zero("rst");

    // Linear, stall and two-word segment.
    @(negedge CLK);
    push(14'd0); push(14'd1); push(14'd2);
    push(14'd3); push(14'd4); push(14'd6);
    RST = 1'b1;
    tick();
    check("lin_e1_valid", 32'(INSTR_VALID), 32'h0);
    tick();
    check("lin_e2_valid", 32'(INSTR_VALID), 32'h1);
    check("lin_e2_instr", 32'(INSTR), 32'h0);
    check("lin_e2_pc", 32'(INSTR_PC), 32'h0);
    tick();
    check("lin_e3_pc", 32'(INSTR_PC), 32'h1);
    tick();
    check("lin_e4_pc", 32'(INSTR_PC), 32'h2);
    STALL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("stall_pc", 32'(INSTR_PC), 32'h2);
      check("stall_instr", 32'(INSTR), 32'h0F01);
      check("stall_valid", 32'(INSTR_VALID), 32'h1);
      check("stall_pmen", 32'(PM_EN), 32'h0);
    end
    @(posedge CLK);
    #1;
    STALL = 1'b0;
    tick();
    check("post_stall_pc", 32'(INSTR_PC), 32'h3);
    check("post_stall_instr", 32'(INSTR), 32'h9508);
    tick();
    check("two_bubble", 32'(INSTR_VALID), 32'h0);
    tick();
    check("two_valid", 32'(INSTR_VALID), 32'h1);
    check("two_k", 32'(INSTR_K), 32'h0010);
    check("two_npc", 32'(INSTR_NPC), 32'h6);
    tick();
    check("after_two_pc", 32'(INSTR_PC), 32'h6);
    tick();
    check("pc7", 32'(INSTR_PC), 32'h7);

    // Redirect while stalled.
    STALL = 1'b1;
    REDIRECT = 1'b1;
    REDIRECT_PC = 14'h0010;
    push(14'h0010);
    #1;
    check("redir_pmaddr", 32'(PM_ADDR), 32'h10);
    check("redir_pmen", 32'(PM_EN), 32'h1);
    tick();
    REDIRECT = 1'b0;
    check("redir_bubble", 32'(INSTR_VALID), 32'h0);
    tick();
    check("redir_valid", 32'(INSTR_VALID), 32'h1);
    check("redir_instr", 32'(INSTR), 32'hCFFF);
    check("redir_pc", 32'(INSTR_PC), 32'h10);
    STALL = 1'b0;
    tick();
    STALL = 1'b1;

    // Two-word instruction across the address wrap.
    mem[16383] = 16'h9000;
    mem[0]     = 16'h0100;
    REDIRECT = 1'b1;
    REDIRECT_PC = 14'h3FFF;
    push(14'h3FFF);
    tick();
    REDIRECT = 1'b0;
    check("wrap_bubble1", 32'(INSTR_VALID), 32'h0);
    tick();
    check("wrap_bubble2", 32'(INSTR_VALID), 32'h0);
    tick();
    check("wrap_valid", 32'(INSTR_VALID), 32'h1);
    check("wrap_k", 32'(INSTR_K), 32'h0100);
    check("wrap_npc", 32'(INSTR_NPC), 32'h1);
    STALL = 1'b0;
    tick();
    STALL = 1'b1;

    // Async reset while waiting for a second word.
    REDIRECT = 1'b1;
    REDIRECT_PC = 14'h0004;
    tick();
    REDIRECT = 1'b0;
    tick();
    check("w2_instr", 32'(INSTR), 32'h940C);
    check("w2_valid", 32'(INSTR_VALID), 32'h0);
    #2;
    RST = 1'b0;
    #1;
    chk_zero("arst");

    mem[0] = 16'h0000;
    STALL = 1'b0;
    push(14'd0); push(14'd1); push(14'd2);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check("re_e1_valid", 32'(INSTR_VALID), 32'h0);
    tick();
    check("re_e2_valid", 32'(INSTR_VALID), 32'h1);
    check("re_e2_pc", 32'(INSTR_PC), 32'h0);
    tick();
    check("re_e3_pc", 32'(INSTR_PC), 32'h1);
    tick();
    check("re_e4_pc", 32'(INSTR_PC), 32'h2);
    tick();
    check("re_e5_pc", 32'(INSTR_PC), 32'h3);
    STALL = 1'b1;
    repeat (3) tick();
    check("end_hold_pc", 32'(INSTR_PC), 32'h3);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
